// File: rtl/hazard_stall_unit.sv
// Hazard and stall control for a five-stage pipeline with branches resolved in ID.
// It handles load-use and branch-operand hazards, data-memory wait states,
// a mem-stall watchdog with a sticky timeout flag, and a saturating stall counter.
module hazard_stall_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_uses_rs2,
   input  logic        id_is_branch,
   input  logic        ex_regwrite,
   input  logic        ex_memread,
   input  logic [4:0]  ex_rd,
   input  logic        branch_taken,
   input  logic        dmem_req,
   input  logic        dmem_ready,
   output logic        pc_write,
   output logic        if_id_write,
   output logic        id_ex_bubble,
   output logic        if_id_flush,
   output logic        pipe_freeze,
   output logic        mem_timeout,
   output logic [15:0] stall_count
);

   // RUN is normal flow; BR_STALL is the second bubble of a load feeding a branch.
   typedef enum logic {
      RUN      = 1'b0,
      BR_STALL = 1'b1
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [7:0]  watchdog;
   logic [7:0]  watchdog_next;

   logic        mem_stall;
   logic        dep1;
   logic        dep2;
   logic        dep;
   logic        load_use;
   logic        alu_branch;
   logic        load_branch;

   // x0 is never a real producer, so a zero destination can never create a dependency.
   assign mem_stall   = dmem_req & ~dmem_ready;
   assign dep1        = (ex_rd != 5'd0) & (ex_rd == id_rs1);
   assign dep2        = (ex_rd != 5'd0) & id_uses_rs2 & (ex_rd == id_rs2);
   assign dep         = dep1 | dep2;
   assign load_use    = ex_memread & dep;
   assign alu_branch  = id_is_branch & ex_regwrite & ~ex_memread & dep;
   assign load_branch = id_is_branch & ex_memread & dep;

   // State register; reset aborts any in-flight branch stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   // Next state and stall controls, priority: reset, mem wait, BR_STALL, hazard, branch flush.
   always_comb begin
      state_next   = state;
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_bubble = 1'b0;
      if_id_flush  = 1'b0;
      pipe_freeze  = 1'b0;
      if (!rst_n) begin
         state_next   = RUN;
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
         if_id_flush  = 1'b1;
      end else if (mem_stall) begin
         pipe_freeze  = 1'b1;
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
      end else if (state == BR_STALL) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
         state_next   = RUN;
      end else if (load_use | alu_branch) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
         if (load_branch) begin
            state_next = BR_STALL;
         end
      end else begin
         if_id_flush  = branch_taken & id_is_branch;
      end
   end

   // Watchdog counts consecutive memory wait cycles and saturates at its maximum.
   always_comb begin
      watchdog_next = 8'd0;
      if (mem_stall) begin
         watchdog_next = (watchdog == 8'hFF) ? 8'hFF : watchdog + 8'd1;
      end
   end

   // Watchdog register and sticky timeout; only reset clears the timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         watchdog    <= 8'd0;
         mem_timeout <= 1'b0;
      end else begin
         watchdog    <= watchdog_next;
         mem_timeout <= mem_timeout | (watchdog_next == 8'hFF);
      end
   end

   // Stall counter advances on every cycle the PC is held, saturating at all ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count <= 16'd0;
      end else if (!pc_write && (stall_count != 16'hFFFF)) begin
         stall_count <= stall_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed scoreboard bench for hazard_stall_unit.
module tb_hazard_stall_unit;

   logic        clk;
   logic        rst_n;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        id_uses_rs2;
   logic        id_is_branch;
   logic        ex_regwrite;
   logic        ex_memread;
   logic [4:0]  ex_rd;
   logic        branch_taken;
   logic        dmem_req;
   logic        dmem_ready;
   logic        pc_write;
   logic        if_id_write;
   logic        id_ex_bubble;
   logic        if_id_flush;
   logic        pipe_freeze;
   logic        mem_timeout;
   logic [15:0] stall_count;

   typedef struct {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       uses_rs2;
      logic       is_branch;
      logic       regwrite;
      logic       memread;
      logic [4:0] rd;
      logic       taken;
      logic       req;
      logic       ready;
      logic       rstn;
   } stim_t;

   typedef struct {
      string       tag;
      logic [4:0]  flags;
      logic        tmo;
      logic [15:0] count;
   } exp_t;

   // flag order: {pc_write, if_id_write, id_ex_bubble, if_id_flush, pipe_freeze}
   localparam logic [4:0] RUN_OK    = 5'b11000;
   localparam logic [4:0] RUN_FLUSH = 5'b11010;
   localparam logic [4:0] STALL     = 5'b00100;
   localparam logic [4:0] FREEZE    = 5'b00001;
   localparam logic [4:0] RST       = 5'b00110;

   exp_t        exp_q[$];
   logic [15:0] exp_count;
   int          assert_count;
   int          fail_count;

   hazard_stall_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_uses_rs2  (id_uses_rs2),
      .id_is_branch (id_is_branch),
      .ex_regwrite  (ex_regwrite),
      .ex_memread   (ex_memread),
      .ex_rd        (ex_rd),
      .branch_taken (branch_taken),
      .dmem_req     (dmem_req),
      .dmem_ready   (dmem_ready),
      .pc_write     (pc_write),
      .if_id_write  (if_id_write),
      .id_ex_bubble (id_ex_bubble),
      .if_id_flush  (if_id_flush),
      .pipe_freeze  (pipe_freeze),
      .mem_timeout  (mem_timeout),
      .stall_count  (stall_count)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic stim_t idle();
      stim_t s;
      s.rs1       = 5'd1;
      s.rs2       = 5'd2;
      s.uses_rs2  = 1'b0;
      s.is_branch = 1'b0;
      s.regwrite  = 1'b0;
      s.memread   = 1'b0;
      s.rd        = 5'd0;
      s.taken     = 1'b0;
      s.req       = 1'b0;
      s.ready     = 1'b1;
      s.rstn      = 1'b1;
      return s;
   endfunction

   task automatic drive(input stim_t s);
      id_rs1       = s.rs1;
      id_rs2       = s.rs2;
      id_uses_rs2  = s.uses_rs2;
      id_is_branch = s.is_branch;
      ex_regwrite  = s.regwrite;
      ex_memread   = s.memread;
      ex_rd        = s.rd;
      branch_taken = s.taken;
      dmem_req     = s.req;
      dmem_ready   = s.ready;
      rst_n        = s.rstn;
   endtask

   task automatic applyStimulus(input string tag, input stim_t s, input logic [4:0] flags, input logic tmo);
      exp_t e;
      @(negedge clk);
      drive(s);
      if (!s.rstn) exp_count = 16'd0;
      e.tag   = tag;
      e.flags = flags;
      e.tmo   = tmo;
      e.count = exp_count;
      exp_q.push_back(e);
      if (s.rstn && !flags[4] && (exp_count != 16'hFFFF)) exp_count = exp_count + 16'd1;
   endtask

   task automatic check_field(input string tag, input string field, input logic [15:0] obs, input logic [15:0] expv);
      assert_count++;
      assert (obs === expv) else begin
         fail_count++;
         $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, field, obs, expv);
      end
   endtask

   task automatic checkOutput();
      exp_t e;
      #1;
      assert_count++;
      assert (exp_q.size() > 0) else begin
         fail_count++;
         $error("[TB] FAIL scoreboard_empty observed=0 expected>0");
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_field(e.tag, "pc_write",     16'(pc_write),     16'(e.flags[4]));
         check_field(e.tag, "if_id_write",  16'(if_id_write),  16'(e.flags[3]));
         check_field(e.tag, "id_ex_bubble", 16'(id_ex_bubble), 16'(e.flags[2]));
         check_field(e.tag, "if_id_flush",  16'(if_id_flush),  16'(e.flags[1]));
         check_field(e.tag, "pipe_freeze",  16'(pipe_freeze),  16'(e.flags[0]));
         check_field(e.tag, "mem_timeout",  16'(mem_timeout),  16'(e.tmo));
         check_field(e.tag, "stall_count",  stall_count,       e.count);
      end
   endtask

   task automatic step(input string tag, input stim_t s, input logic [4:0] flags, input logic tmo);
      applyStimulus(tag, s, flags, tmo);
      checkOutput();
   endtask

   initial begin
      stim_t s;
      stim_t rs;
      stim_t lb;
      assert_count = 0;
      fail_count   = 0;
      exp_count    = 16'd0;
      rs = idle();
      rs.rstn = 1'b0;
      drive(rs);

      // reset values
      step("reset0", rs, RST, 1'b0);
      step("reset1", rs, RST, 1'b0);
      step("idle", idle(), RUN_OK, 1'b0);

      // branch flush only for a taken branch
      s = idle(); s.is_branch = 1'b1;
      step("br_not_taken", s, RUN_OK, 1'b0);
      s.taken = 1'b1;
      step("br_taken", s, RUN_FLUSH, 1'b0);
      s = idle(); s.taken = 1'b1;
      step("taken_no_branch", s, RUN_OK, 1'b0);

      // load-use on rs1
      s = idle(); s.memread = 1'b1; s.rd = 5'd5; s.rs1 = 5'd5;
      step("load_use", s, STALL, 1'b0);
      step("after_load_use", idle(), RUN_OK, 1'b0);

      // rs2 dependency only counts when rs2 is used
      s = idle(); s.memread = 1'b1; s.rd = 5'd6; s.rs2 = 5'd6;
      step("rs2_unused", s, RUN_OK, 1'b0);
      s.uses_rs2 = 1'b1;
      step("rs2_used", s, STALL, 1'b0);

      // load-to-branch: two stalls with flush suppressed, then RUN
      lb = idle(); lb.is_branch = 1'b1; lb.memread = 1'b1; lb.rd = 5'd7;
      lb.rs2 = 5'd7; lb.uses_rs2 = 1'b1; lb.taken = 1'b1;
      step("ld_br_1", lb, STALL, 1'b0);
      s = idle(); s.is_branch = 1'b1; s.taken = 1'b1;
      step("ld_br_2", s, STALL, 1'b0);
      step("ld_br_run", s, RUN_FLUSH, 1'b0);

      // ALU-to-branch one stall; x0 never stalls
      s = idle(); s.regwrite = 1'b1; s.rd = 5'd3; s.rs1 = 5'd3; s.is_branch = 1'b1; s.taken = 1'b1;
      step("alu_br", s, STALL, 1'b0);
      s.rd = 5'd0; s.rs1 = 5'd0;
      step("alu_br_x0", s, RUN_FLUSH, 1'b0);
      s = idle(); s.memread = 1'b1; s.rd = 5'd0; s.rs1 = 5'd0;
      step("load_x0", s, RUN_OK, 1'b0);
      s = idle(); s.regwrite = 1'b1; s.rd = 5'd3; s.rs1 = 5'd3;
      step("alu_no_branch", s, RUN_OK, 1'b0);

      // mem stall outranks load-use
      s = idle(); s.memread = 1'b1; s.rd = 5'd5; s.rs1 = 5'd5; s.req = 1'b1; s.ready = 1'b0;
      step("freeze_over_lu", s, FREEZE, 1'b0);
      s.ready = 1'b1;
      step("lu_after_freeze", s, STALL, 1'b0);

      // mem stall while in BR_STALL holds the state
      step("brs_enter", lb, STALL, 1'b0);
      s = idle(); s.is_branch = 1'b1; s.taken = 1'b1; s.req = 1'b1; s.ready = 1'b0;
      for (int i = 0; i < 3; i++) step("brs_freeze", s, FREEZE, 1'b0);
      s.ready = 1'b1;
      step("brs_resume", s, STALL, 1'b0);
      step("brs_run", s, RUN_FLUSH, 1'b0);

      // reset during BR_STALL aborts it
      step("rst_brs_enter", lb, STALL, 1'b0);
      step("rst_brs", rs, RST, 1'b0);
      s = idle(); s.is_branch = 1'b1; s.taken = 1'b1;
      step("rst_brs_run", s, RUN_FLUSH, 1'b0);

      // watchdog clears on a gap between wait runs
      s = idle(); s.req = 1'b1; s.ready = 1'b0;
      for (int i = 0; i < 200; i++) step("wd_run_a", s, FREEZE, 1'b0);
      step("wd_gap", idle(), RUN_OK, 1'b0);
      for (int i = 0; i < 100; i++) step("wd_run_b", s, FREEZE, 1'b0);
      step("wd_gap2", idle(), RUN_OK, 1'b0);

      // 255 consecutive waits set the sticky timeout
      for (int i = 0; i < 255; i++) step("wd_count", s, FREEZE, 1'b0);
      step("wd_timeout", s, FREEZE, 1'b1);
      step("wd_sticky", idle(), RUN_OK, 1'b1);
      step("wd_sticky2", idle(), RUN_OK, 1'b1);
      step("wd_reset", rs, RST, 1'b0);
      step("wd_cleared", idle(), RUN_OK, 1'b0);

      // stall_count saturation
      s = idle(); s.memread = 1'b1; s.rd = 5'd9; s.rs1 = 5'd9;
      step("sat_first", s, STALL, 1'b0);
      repeat (65533) @(negedge clk);
      exp_count = exp_count + 16'd65533;
      step("sat_fffe", s, STALL, 1'b0);
      step("sat_ffff", s, STALL, 1'b0);
      step("sat_hold", s, STALL, 1'b0);
      step("sat_idle", idle(), RUN_OK, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule

// File: doc/hazard_stall_unit.md
HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 The block SHALL have one clock and reset: clk input 1 (rising edge); rst_n input 1 (asynchronous, active-low).
REQ-002 id_rs1, id_rs2 input 5 each SHALL carry the source registers of the instruction in ID.
REQ-003 id_uses_rs2 input 1 SHALL flag that the ID instruction reads rs2; id_is_branch input 1 SHALL flag a branch resolved in ID.
REQ-004 ex_regwrite input 1, ex_memread input 1, ex_rd input 5 SHALL describe the instruction in EX.
REQ-005 branch_taken input 1 SHALL flag that the ID comparator resolved the branch as taken.
REQ-006 dmem_req input 1 and dmem_ready input 1 SHALL be the data-memory access handshake of the MEM stage.
REQ-007 pc_write output 1 and if_id_write output 1 SHALL be the PC and IF/ID write enables, 1 = advance.
REQ-008 id_ex_bubble output 1 SHALL zero ID/EX control signals; if_id_flush output 1 SHALL clear the IF/ID register.
REQ-009 pipe_freeze output 1 SHALL hold ID/EX, EX/MEM and MEM/WB; mem_timeout output 1 SHALL be a sticky error flag; stall_count output 16 SHALL count stall cycles.

Function
REQ-010 States SHALL be RUN and BR_STALL; outputs SHALL be combinational from state and inputs; state, watchdog and stall_count SHALL be registered.
REQ-011 mem_stall = dmem_req & ~dmem_ready; dep1 = ex_rd!=0 & ex_rd==id_rs1; dep2 = ex_rd!=0 & id_uses_rs2 & ex_rd==id_rs2; dep = dep1|dep2.
REQ-012 Priority SHALL be mem_stall > BR_STALL > hazard in RUN > branch flush.
REQ-013 mem_stall in any state SHALL give pipe_freeze=1, pc_write=0, if_id_write=0, id_ex_bubble=0, if_id_flush=0, and state SHALL hold.
REQ-014 RUN, no mem_stall, ex_memread & dep (load-use) SHALL give pc_write=0, if_id_write=0, id_ex_bubble=1 for one cycle.
REQ-015 RUN, no mem_stall, id_is_branch & ex_regwrite & ~ex_memread & dep SHALL give a one-cycle stall (as REQ-014) and remain in RUN.
REQ-016 RUN, no mem_stall, id_is_branch & ex_memread & dep SHALL stall as REQ-014 and move to BR_STALL.
REQ-017 BR_STALL, no mem_stall, SHALL stall unconditionally (pc_write=0, if_id_write=0, id_ex_bubble=1) and return to RUN; total load-to-branch stall is 2 cycles.
REQ-018 In any cycle with a stall of REQ-014..017, branch_taken SHALL be ignored (if_id_flush=0).
REQ-019 RUN with no stall SHALL give pc_write=1, if_id_write=1, id_ex_bubble=0, pipe_freeze=0, and if_id_flush=branch_taken & id_is_branch.
REQ-020 Hazards SHALL never fire for ex_rd=0, regardless of ex_regwrite or ex_memread.
REQ-021 stall_count SHALL increment by 1 on each clock edge where pc_write=0 and rst_n=1, and SHALL saturate at 0xFFFF.
REQ-022 The 8-bit watchdog SHALL count consecutive mem_stall cycles and clear on any cycle without mem_stall.
REQ-023 When the watchdog reaches 255, mem_timeout SHALL set and remain set until reset; freezing SHALL continue.

Reset
REQ-024 While rst_n=0: state=RUN, watchdog=0, stall_count=0, mem_timeout=0, pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=1, pipe_freeze=0.
REQ-025 Reset asserted in BR_STALL or during mem_stall SHALL abort the stall; the first cycle after release SHALL evaluate in RUN.

Verification
REQ-026 Load-use: ex_memread=1, ex_rd=5, id_rs1=5 -> one cycle with pc_write=0, id_ex_bubble=1; stall_count 0->1.
REQ-027 Load-to-branch: id_is_branch=1, ex_memread=1, ex_rd=7, id_rs2=7, id_uses_rs2=1, branch_taken=1 -> two stall cycles, if_id_flush=0 in both, then RUN.
REQ-028 ALU-to-branch and x0: ex_regwrite=1, ex_rd=3=id_rs1, id_is_branch=1 -> one stall; the same with ex_rd=0 -> no stall.
REQ-029 Mem stall in BR_STALL: dmem_ready=0 for 3 cycles -> pipe_freeze=1 for 3 cycles, state held, then 1 BR_STALL cycle, stall_count +4.
REQ-030 Watchdog: dmem_req=1, dmem_ready=0 for 255 cycles -> mem_timeout=1 and sticky after dmem_ready=1; rst_n pulse -> 0.
REQ-031 Saturation: preload 0xFFFE, 3 stall cycles -> stall_count=0xFFFF.
